// File: rtl/fifo_ptr_ctrl.sv
// FIFO read/write pointer controller with registered occupancy and status flags.
// Define FIFO_PTR_CTRL_ERR_EN to build the sticky overflow/underflow error flags.
module fifo_ptr_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int AF_MARGIN  = 2,
    parameter int AE_MARGIN  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_ena,
    input  logic                  read_ena,
    input  logic                  flush,
    input  logic                  err_clr,
    output logic [ADDR_WIDTH:0]   write_addr,
    output logic [ADDR_WIDTH:0]   read_addr,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(DEPTH - AF_MARGIN);
    localparam logic [PTR_W-1:0] AE_LEVEL = PTR_W'(AE_MARGIN);

    logic             wr_acc;
    logic             rd_acc;
    logic [PTR_W-1:0] wr_next;
    logic [PTR_W-1:0] rd_next;
    logic [PTR_W-1:0] count_next;
    logic             empty_next;
    logic             full_next;

    // Strobes are suppressed while in reset or flushing so the RAM never sees a stray access.
    assign wr_acc = rst_n & ~flush & write_ena & ~full;
    assign rd_acc = rst_n & ~flush & read_ena & ~empty;
    assign mem_we = wr_acc;
    assign mem_re = rd_acc;

    always_comb begin
        wr_next = write_addr;
        rd_next = read_addr;
        if (flush) begin
            wr_next = '0;
            rd_next = '0;
        end else begin
            if (wr_acc) wr_next = write_addr + PTR_W'(1);
            if (rd_acc) rd_next = read_addr + PTR_W'(1);
        end
    end

    // The extra wrap bit makes the modular difference an exact occupancy, 0..DEPTH.
    assign count_next = wr_next - rd_next;
    assign empty_next = (wr_next == rd_next);
    assign full_next  = (wr_next[ADDR_WIDTH] != rd_next[ADDR_WIDTH]) &&
                        (wr_next[ADDR_WIDTH-1:0] == rd_next[ADDR_WIDTH-1:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_addr   <= '0;
            read_addr    <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
        end else begin
            write_addr   <= wr_next;
            read_addr    <= rd_next;
            count        <= count_next;
            empty        <= empty_next;
            full         <= full_next;
            almost_empty <= (count_next <= AE_LEVEL);
            almost_full  <= (count_next >= AF_LEVEL);
        end
    end

`ifdef FIFO_PTR_CTRL_ERR_EN
    // A new error event wins over a simultaneous clear; flush leaves the flags alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_ena && full)  overflow <= 1'b1;
            else if (err_clr)       overflow <= 1'b0;
            if (read_ena && empty)  underflow <= 1'b1;
            else if (err_clr)       underflow <= 1'b0;
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed self-checking bench for fifo_ptr_ctrl (ADDR_WIDTH=3, DEPTH=8, margins 2).
// Error-flag expectations follow whether FIFO_PTR_CTRL_ERR_EN is defined.
module tb_fifo_ptr_ctrl;

`ifdef FIFO_PTR_CTRL_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       write_ena;
    logic       read_ena;
    logic       flush;
    logic       err_clr;
    logic [3:0] write_addr;
    logic [3:0] read_addr;
    logic       mem_we;
    logic       mem_re;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    int assertCount = 0;
    int failCount   = 0;

    fifo_ptr_ctrl #(
        .ADDR_WIDTH (3),
        .AF_MARGIN  (2),
        .AE_MARGIN  (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_ena    (write_ena),
        .read_ena     (read_ena),
        .flush        (flush),
        .err_clr      (err_clr),
        .write_addr   (write_addr),
        .read_addr    (read_addr),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, check the combinational strobes, then step past the edge.
    task automatic applyStimulus(input string tag, input logic we, input logic re, input logic fl,
                                 input logic ec, input logic exp_we, input logic exp_re);
        write_ena = we;
        read_ena  = re;
        flush     = fl;
        err_clr   = ec;
        #1;
        checkOutput({tag, ".mem_we"}, 32'(mem_we), 32'(exp_we));
        checkOutput({tag, ".mem_re"}, 32'(mem_re), 32'(exp_re));
        @(posedge clk);
        #1;
        write_ena = 1'b0;
        read_ena  = 1'b0;
        flush     = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic checkState(input string tag, input int wa, input int ra, input int cnt,
                              input bit f, input bit e, input bit af, input bit ae,
                              input bit ov, input bit un);
        checkOutput({tag, ".write_addr"},   32'(write_addr),   32'(wa));
        checkOutput({tag, ".read_addr"},    32'(read_addr),    32'(ra));
        checkOutput({tag, ".count"},        32'(count),        32'(cnt));
        checkOutput({tag, ".full"},         32'(full),         32'(f));
        checkOutput({tag, ".empty"},        32'(empty),        32'(e));
        checkOutput({tag, ".almost_full"},  32'(almost_full),  32'(af));
        checkOutput({tag, ".almost_empty"}, 32'(almost_empty), 32'(ae));
        checkOutput({tag, ".overflow"},     32'(overflow),     32'(ov));
        checkOutput({tag, ".underflow"},    32'(underflow),    32'(un));
    endtask

    initial begin
        rst_n     = 1'b0;
        write_ena = 1'b1;
        read_ena  = 1'b0;
        flush     = 1'b0;
        err_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.mem_we", 32'(mem_we), 32'(0));
        checkState("rst", 0, 0, 0, 0, 1, 0, 1, 0, 0);

        // Fill from empty; the very first edge after reset release must accept.
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("fill%0d", i), 1, 0, 0, 0, 1, 0);
            checkState($sformatf("fill%0d", i), i + 1, 0, i + 1, (i == 7), 0,
                       (i + 1 >= 6), (i + 1 <= 2), 0, 0);
        end

        applyStimulus("ovf", 1, 0, 0, 0, 0, 0);
        checkState("ovf", 8, 0, 8, 1, 0, 1, 0, ERR, 0);

        applyStimulus("fullrw", 1, 1, 0, 0, 0, 1);
        checkState("fullrw", 8, 1, 7, 0, 0, 1, 0, ERR, 0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus($sformatf("drain%0d", i), 0, 1, 0, 0, 0, 1);
            checkState($sformatf("drain%0d", i), 8, 2 + i, 6 - i, 0, 0, (6 - i >= 6), 0, ERR, 0);
        end

        // Steady streaming at count 4 carries both pointers across the 15 -> 0 wrap.
        for (int i = 0; i < 20; i++) begin
            applyStimulus($sformatf("stream%0d", i), 1, 1, 0, 0, 1, 1);
            checkState($sformatf("stream%0d", i), (9 + i) % 16, (5 + i) % 16, 4, 0, 0, 0, 0, ERR, 0);
        end

        applyStimulus("to5", 1, 0, 0, 0, 1, 0);
        checkState("to5", 13, 8, 5, 0, 0, 0, 0, ERR, 0);

        applyStimulus("flush", 1, 1, 1, 0, 0, 0);
        checkState("flush", 0, 0, 0, 0, 1, 0, 1, ERR, 0);

        applyStimulus("udf", 0, 1, 0, 0, 0, 0);
        checkState("udf", 0, 0, 0, 0, 1, 0, 1, ERR, ERR);

        applyStimulus("udf_clr", 0, 1, 0, 1, 0, 0);
        checkState("udf_clr", 0, 0, 0, 0, 1, 0, 1, 0, ERR);

        applyStimulus("emptyrw", 1, 1, 0, 0, 1, 0);
        checkState("emptyrw", 1, 0, 1, 0, 0, 0, 1, 0, ERR);

        applyStimulus("errclr", 0, 0, 0, 1, 0, 0);
        checkState("errclr", 1, 0, 1, 0, 0, 0, 1, 0, 0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus($sformatf("refill%0d", i), 1, 0, 0, 0, 1, 0);
            checkState($sformatf("refill%0d", i), 2 + i, 0, 2 + i, 0, 0, (2 + i >= 6), (2 + i <= 2), 0, 0);
        end

        rst_n = 1'b0;
        applyStimulus("midrst", 1, 0, 0, 0, 0, 0);
        checkState("midrst", 0, 0, 0, 0, 1, 0, 1, 0, 0);

        rst_n = 1'b1;
        applyStimulus("postrst", 1, 0, 0, 0, 1, 0);
        checkState("postrst", 1, 0, 1, 0, 0, 0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
